// File: rtl/riscv_pkg.sv
// Shared store-path types: store size encoding and the store buffer entry record.
// Entry fields are sized for the widest datapath; narrower builds zero-extend into them.
package riscv_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [2:0] {
    STN = 3'd0,
    STB = 3'd1,
    STH = 3'd2,
    STW = 3'd3,
    STD = 3'd4
  } store_op_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0]   addr;
    logic [XLEN_MAX-1:0]   data;
    logic [XLEN_MAX/8-1:0] strobe;
  } store_buffer_entry_t;

  // Byte count of a store; STD is a no-op on a 32-bit datapath.
  function automatic logic [3:0] store_size(store_op_e op, int xlen);
    case (op)
      STB:     store_size = 4'd1;
      STH:     store_size = 4'd2;
      STW:     store_size = 4'd4;
      STD:     store_size = (xlen == 64) ? 4'd8 : 4'd0;
      default: store_size = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_align.sv
// Combinational lane placement: turns one store into one or two word-aligned beats.
module store_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  store_op_e           i_op,
  input  logic [XLEN-1:0]     i_addr,
  input  logic [XLEN-1:0]     i_data,
  output logic                o_enq,
  output logic                o_split,
  output store_buffer_entry_t o_lo,
  output store_buffer_entry_t o_hi
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  logic [3:0]         w_size;
  logic [OFFW-1:0]    w_off;
  logic [2*BYTES-1:0] w_mask;
  logic [2*BYTES-1:0] w_strb_wide;
  logic [2*XLEN-1:0]  w_data_wide;
  logic [XLEN-1:0]    w_word_addr;
  logic [XLEN-1:0]    w_next_addr;

  // Both beats come from one double-width shift; the upper half is the spill-over beat.
  always_comb begin
    w_size      = store_size(i_op, XLEN);
    w_off       = i_addr[OFFW-1:0];
    w_mask      = (2*BYTES)'((32'd1 << w_size) - 32'd1);
    w_strb_wide = w_mask << w_off;
    w_data_wide = {{XLEN{1'b0}}, i_data} << {w_off, 3'b000};
    w_word_addr = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    w_next_addr = w_word_addr + XLEN'(BYTES);
  end

  assign o_enq   = (w_size != 4'd0);
  assign o_split = |w_strb_wide[2*BYTES-1:BYTES];

  always_comb begin
    o_lo        = '0;
    o_hi        = '0;
    o_lo.addr   = XLEN_MAX'(w_word_addr);
    o_lo.data   = XLEN_MAX'(w_data_wide[XLEN-1:0]);
    o_lo.strobe = (XLEN_MAX/8)'(w_strb_wide[BYTES-1:0]);
    o_hi.addr   = XLEN_MAX'(w_next_addr);
    o_hi.data   = XLEN_MAX'(w_data_wide[2*XLEN-1:XLEN]);
    o_hi.strobe = (XLEN_MAX/8)'(w_strb_wide[2*BYTES-1:BYTES]);
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: FIFO of aligned write beats between EX and memory, with a load-ordering check.
// Ready requires two free slots so a split store always lands both beats in one cycle.
module store_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_store_valid,
  output logic                       o_store_ready,
  input  store_op_e                  i_store_operation,
  input  logic [XLEN-1:0]            i_store_address,
  input  logic [XLEN-1:0]            i_store_data,
  output logic                       o_mem_valid,
  input  logic                       i_mem_ready,
  output logic [XLEN-1:0]            o_mem_address,
  output logic [XLEN-1:0]            o_mem_write_data,
  output logic [XLEN/8-1:0]          o_mem_byte_write_enable,
  input  logic [XLEN-1:0]            i_load_check_address,
  output logic                       o_load_hazard,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int OFFW = $clog2(XLEN / 8);

  store_buffer_entry_t r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  logic                w_enq;
  logic                w_split;
  store_buffer_entry_t w_lo;
  store_buffer_entry_t w_hi;
  store_buffer_entry_t w_head;
  logic                w_push;
  logic                w_pop;
  logic [CW-1:0]       w_n_push;
  logic [XLEN_MAX-1:0] w_check_word;

  store_align #(.XLEN(XLEN)) u_align (
    .i_op    (i_store_operation),
    .i_addr  (i_store_address),
    .i_data  (i_store_data),
    .o_enq   (w_enq),
    .o_split (w_split),
    .o_lo    (w_lo),
    .o_hi    (w_hi)
  );

  assign o_store_ready = (r_count <= CW'(DEPTH - 2));
  assign w_push        = i_store_valid & o_store_ready & w_enq;
  assign w_pop         = o_mem_valid & i_mem_ready;
  assign w_n_push      = !w_push ? CW'(0) : (w_split ? CW'(2) : CW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_n_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + w_n_push - CW'(w_pop);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_lo;
      if (w_split) r_mem[r_wr_ptr + PW'(1)] <= w_hi;
    end
  end

  assign w_head                  = r_mem[r_rd_ptr];
  assign o_mem_valid             = (r_count != '0);
  assign o_empty                 = (r_count == '0);
  assign o_count                 = r_count;
  assign o_mem_address           = o_mem_valid ? w_head.addr[XLEN-1:0]     : '0;
  assign o_mem_write_data        = o_mem_valid ? w_head.data[XLEN-1:0]     : '0;
  assign o_mem_byte_write_enable = o_mem_valid ? w_head.strobe[XLEN/8-1:0] : '0;

  assign w_check_word = XLEN_MAX'({i_load_check_address[XLEN-1:OFFW], {OFFW{1'b0}}});

  always_comb begin
    logic [PW-1:0] rel;
    o_load_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - r_rd_ptr;
      if (({1'b0, rel} < r_count) && (r_mem[i].addr == w_check_word))
        o_load_hazard = 1'b1;
    end
  end

  logic w_unused_lo;
  assign w_unused_lo = ^i_load_check_address[OFFW-1:0];

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic w_unused_hi;
    assign w_unused_hi = ^{w_head.data[XLEN_MAX-1:XLEN], w_head.strobe[XLEN_MAX/8-1:XLEN/8]};
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (XLEN=32, DEPTH=4): directed scenarios plus a
// randomized run against a byte-lane queue model.
module tb_store_buffer;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              store_valid = 1'b0;
  logic              store_ready;
  store_op_e         store_op = STN;
  logic [XLEN-1:0]   store_addr = '0;
  logic [XLEN-1:0]   store_data = '0;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_data;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   chk_addr = '0;
  logic              hazard;
  logic              empty;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;
  beat_t model_q[$];

  always #5 clk = ~clk;

  store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_store_valid           (store_valid),
    .o_store_ready           (store_ready),
    .i_store_operation       (store_op),
    .i_store_address         (store_addr),
    .i_store_data            (store_data),
    .o_mem_valid             (mem_valid),
    .i_mem_ready             (mem_ready),
    .o_mem_address           (mem_addr),
    .o_mem_write_data        (mem_data),
    .o_mem_byte_write_enable (mem_be),
    .i_load_check_address    (chk_addr),
    .o_load_hazard           (hazard),
    .o_empty                 (empty),
    .o_count                 (count)
  );

  function automatic int op_bytes(store_op_e op);
    case (op)
      STB:     return 1;
      STH:     return 2;
      STW:     return 4;
      default: return 0;
    endcase
  endfunction

  // Model: lay the store's bytes into an 8-lane window starting at addr%4, then cut into words.
  task automatic model_push(store_op_e op, logic [31:0] addr, logic [31:0] data);
    logic [7:0] lane_d[8];
    logic       lane_s[8];
    int         n;
    int         off;
    beat_t      b;
    n   = op_bytes(op);
    off = int'(addr % 4);
    if (n == 0) return;
    for (int i = 0; i < 8; i++) begin
      lane_d[i] = 8'h00;
      lane_s[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      lane_d[off+i] = data[8*i +: 8];
      lane_s[off+i] = (i < n);
    end
    for (int w = 0; w < 2; w++) begin
      b.addr = (addr - (addr % 4)) + 32'(4 * w);
      b.data = {lane_d[4*w+3], lane_d[4*w+2], lane_d[4*w+1], lane_d[4*w]};
      b.be   = {lane_s[4*w+3], lane_s[4*w+2], lane_s[4*w+1], lane_s[4*w]};
      if (w == 0 || b.be != 4'b0000) model_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    store_valid = 1'b0;
    mem_ready = 1'b0;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (store_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", store_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({mem_addr, mem_data, mem_be, hazard} !== '0) begin bad++; $display("FAIL reset_outputs got=%h/%h/%b/%b exp=0", mem_addr, mem_data, mem_be, hazard); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single(string name, store_op_e op, logic [31:0] a, logic [31:0] d,
                             logic [31:0] ea, logic [31:0] ed, logic [3:0] ebe);
    mem_ready = 1'b1;
    store_valid = 1'b1; store_op = op; store_addr = a; store_data = d;
    tick();
    store_valid = 1'b0;
    total++; if (mem_valid !== 1'b1 || count !== 3'd1) begin bad++; $display("FAIL %s_valid got=%b/%0d exp=1/1", name, mem_valid, count); end
    total++; if ({mem_addr, mem_data, mem_be} !== {ea, ed, ebe}) begin bad++; $display("FAIL %s_beat got=%h/%h/%b exp=%h/%h/%b", name, mem_addr, mem_data, mem_be, ea, ed, ebe); end
    tick();
    total++; if (empty !== 1'b1 || mem_valid !== 1'b0) begin bad++; $display("FAIL %s_drain got=%b/%b exp=1/0", name, empty, mem_valid); end
    mem_ready = 1'b0;
  endtask

  task automatic test_split(string name, logic [31:0] a, logic [31:0] d,
                            logic [31:0] ea0, logic [31:0] ed0, logic [3:0] eb0,
                            logic [31:0] ea1, logic [31:0] ed1, logic [3:0] eb1);
    mem_ready = 1'b0;
    store_valid = 1'b1; store_op = STW; store_addr = a; store_data = d;
    tick();
    store_valid = 1'b0;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL %s_count got=%0d exp=2", name, count); end
    tick();
    total++; if ({mem_addr, mem_data, mem_be} !== {ea0, ed0, eb0}) begin bad++; $display("FAIL %s_low_held got=%h/%h/%b exp=%h/%h/%b", name, mem_addr, mem_data, mem_be, ea0, ed0, eb0); end
    mem_ready = 1'b1;
    tick();
    total++; if ({mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, ea1, ed1, eb1}) begin bad++; $display("FAIL %s_high got=%b/%h/%h/%b exp=1/%h/%h/%b", name, mem_valid, mem_addr, mem_data, mem_be, ea1, ed1, eb1); end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL %s_drain got=%b exp=1", name, empty); end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    store_valid = 1'b1; store_op = STW; store_addr = 32'h3000; store_data = 32'h1;
    for (int i = 0; i < 5; i++) tick();
    store_valid = 1'b0;
    total++; if (count !== 3'd3 || store_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%0d/%b exp=3/0", count, store_ready); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++; if (count !== 3'd2 || store_ready !== 1'b1) begin bad++; $display("FAIL b2b_reopen got=%0d/%b exp=2/1", count, store_ready); end
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%b exp=1", empty); end
  endtask

  task automatic test_hazard();
    mem_ready = 1'b0;
    store_valid = 1'b1; store_op = STW; store_addr = 32'h2004; store_data = 32'h5;
    chk_addr = 32'h2004;
    #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL hazard_inflight got=%b exp=0", hazard); end
    tick();
    store_valid = 1'b0;
    chk_addr = 32'h2006; #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL hazard_hit got=%b exp=1", hazard); end
    chk_addr = 32'h2008; #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL hazard_miss got=%b exp=0", hazard); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk_addr = 32'h2004; #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL hazard_after_drain got=%b exp=0", hazard); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    store_valid = 1'b1; store_op = STW; store_addr = 32'h5000; store_data = 32'h77;
    tick(); tick();
    store_valid = 1'b0;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL rstmid_pre got=%0d exp=2", count); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || mem_addr !== '0) begin bad++; $display("FAIL rstmid_async got=%b/%0d/%b/%h exp=0/0/1/0", mem_valid, count, empty, mem_addr); end
    tick();
    rst = 1'b0;
    store_valid = 1'b1; store_op = STW; store_addr = 32'h4000; store_data = 32'h55AA55AA;
    tick();
    store_valid = 1'b0;
    total++; if ({mem_valid, count, mem_addr, mem_data, mem_be} !== {1'b1, 3'd1, 32'h4000, 32'h55AA55AA, 4'b1111}) begin bad++; $display("FAIL rstmid_after got=%b/%0d/%h/%h/%b exp=1/1/4000/55aa55aa/1111", mem_valid, count, mem_addr, mem_data, mem_be); end
    do_reset();
  endtask

  task automatic test_random();
    store_op_e ops[5] = '{STN, STB, STH, STW, STD};
    logic      exp_ready;
    logic      exp_haz;
    beat_t     h;
    do_reset();
    model_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      store_valid = ($urandom_range(0, 3) != 0);
      store_op    = ops[$urandom_range(0, 4)];
      store_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                : (32'h100 + 32'($urandom_range(0, 31)));
      store_data  = $urandom;
      mem_ready   = ($urandom_range(0, 2) != 0);
      chk_addr    = ($urandom_range(0, 7) == 0) ? 32'h0 : (32'h100 + 32'($urandom_range(0, 35)));
      #1;
      exp_ready = ((DEPTH - model_q.size()) >= 2);
      exp_haz = 1'b0;
      foreach (model_q[k]) if (model_q[k].addr == (chk_addr & ~32'h3)) exp_haz = 1'b1;
      total++; if (store_ready !== exp_ready || count !== 3'(model_q.size())) begin bad++; $display("FAIL rand_occ cyc=%0d got=%b/%0d exp=%b/%0d", cyc, store_ready, count, exp_ready, model_q.size()); end
      total++; if (hazard !== exp_haz) begin bad++; $display("FAIL rand_hazard cyc=%0d chk=%h got=%b exp=%b", cyc, chk_addr, hazard, exp_haz); end
      if (model_q.size() != 0) begin
        h = model_q[0];
        total++; if ({mem_valid, mem_addr, mem_data, mem_be} !== {1'b1, h.addr, h.data, h.be}) begin bad++; $display("FAIL rand_head cyc=%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", cyc, mem_valid, mem_addr, mem_data, mem_be, h.addr, h.data, h.be); end
      end else begin
        total++; if (mem_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL rand_empty cyc=%0d got=%b/%b exp=0/1", cyc, mem_valid, empty); end
      end
      @(posedge clk);
      if (mem_ready && model_q.size() != 0) void'(model_q.pop_front());
      if (store_valid && exp_ready) model_push(store_op, store_addr, store_data);
      #1;
    end
    store_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single("sw_aligned", STW, 32'h1000, 32'hDEADBEEF, 32'h1000, 32'hDEADBEEF, 4'b1111);
    test_single("sb_lane3",   STB, 32'h1003, 32'h000000AB, 32'h1000, 32'hAB000000, 4'b1000);
    test_single("sh_lane1",   STH, 32'h1001, 32'h0000BEEF, 32'h1000, 32'h00BEEF00, 4'b0110);
    test_split("sw_split", 32'h1002, 32'h11223344,
               32'h1000, 32'h33440000, 4'b1100, 32'h1004, 32'h00001122, 4'b0011);
    test_split("sw_wrap", 32'hFFFF_FFFF, 32'hA1B2C3D4,
               32'hFFFF_FFFC, 32'hD4000000, 4'b1000, 32'h0, 32'h00A1B2C3, 4'b0111);
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; a power of two, at least 2.
REQ-003 SHALL have ports i_clk, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports i_store_valid input 1 and o_store_ready output 1: the store request handshake from EX.
REQ-006 SHALL have port i_store_operation, input, riscv_pkg::store_op_e, store size: STB, STH, STW, STD (STD only when XLEN=64) or STN.
REQ-007 SHALL have ports i_store_address input XLEN (byte address, any alignment) and i_store_data input XLEN (rs2 value, right-justified).
REQ-008 SHALL have ports o_mem_valid output 1 and i_mem_ready input 1: the memory write handshake.
REQ-009 SHALL have ports o_mem_address output XLEN (word-aligned), o_mem_write_data output XLEN (lane-aligned) and o_mem_byte_write_enable output XLEN/8.
REQ-010 SHALL have ports i_load_check_address input XLEN and o_load_hazard output 1: load-ordering check.
REQ-011 SHALL have ports o_empty output 1 and o_count output $clog2(DEPTH)+1, the occupancy.

Function
REQ-012 Accept rule: a store SHALL be accepted when i_store_valid and o_store_ready are both 1 on a rising edge.
REQ-013 o_store_ready SHALL be 1 if and only if (DEPTH - count) >= 2; this guarantees room for a split store.
REQ-014 Enqueue: an accepted STN SHALL enqueue nothing.
REQ-015 Lane placement, non-crossing: for BYTES = XLEN/8 and off = addr mod BYTES, data SHALL be shifted left by 8*off and the strobe SHALL be a size-wide ones mask shifted by off.
REQ-016 Misaligned split: if off + size > BYTES, two entries SHALL be enqueued in the same cycle, in this order:
  - low beat: word addr, lanes off..BYTES-1;
  - high beat: word addr + BYTES, remaining bytes in lanes 0 upward.
REQ-017 The word address SHALL be addr with its low $clog2(BYTES) bits cleared; the high beat address SHALL wrap modulo 2^XLEN.
REQ-018 Latency: an entry written at edge N SHALL be at the head and visible on o_mem_* after edge N when the buffer was empty; total latency is 1 cycle.
REQ-019 Head presentation: o_mem_valid SHALL equal (count != 0), and o_mem_* SHALL show the head entry.
REQ-020 Dequeue: the head SHALL be removed when o_mem_valid and i_mem_ready are both 1.
REQ-021 Head stability: o_mem_* SHALL be held stable while o_mem_valid=1 and i_mem_ready=0.
REQ-022 Simultaneous enqueue and dequeue in one cycle SHALL update count by (enqueued - 1); FIFO order SHALL be preserved.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Full: count SHALL never exceed DEPTH.
REQ-025 Empty: o_empty=1 and o_mem_valid=0 when count=0.
REQ-026 o_load_hazard SHALL be combinational and SHALL be 1 if any resident entry's word address equals the word address of i_load_check_address.
REQ-027 An entry being enqueued in the current cycle SHALL NOT contribute to o_load_hazard until the next cycle.

Reset
REQ-028 On i_rst=1, without waiting for a clock edge, the buffer SHALL apply these values:
  - pointers = 0, count = 0;
  - o_mem_valid = 0, o_empty = 1, o_store_ready = 1, o_load_hazard = 0;
  - o_mem_address, o_mem_write_data and o_mem_byte_write_enable = 0.
REQ-029 Entries in flight at reset SHALL be discarded; no partial split SHALL survive.

Structure
REQ-030 riscv_pkg SHALL hold store_op_e (including STD) and a store_buffer_entry_t struct with fields addr, data and strobe.
REQ-031 A combinational sub-module store_align SHALL compute the split decision and both beats, keeping store_buffer limited to storage and handshakes.

Verification
REQ-032 XLEN=32, SW 0x1000 data 0xDEADBEEF, i_mem_ready=1 -> next cycle o_mem_valid=1, addr 0x1000, data 0xDEADBEEF, be 1111.
REQ-033 SB 0x1003 data 0x000000AB -> addr 0x1000, data 0xAB000000, be 1000.
REQ-034 SW 0x1002 data 0x11223344 -> beat 1: 0x1000 / 0x33440000 / be 1100; beat 2: 0x1004 / 0x00001122 / be 0011; count=2 after accept.
REQ-035 DEPTH=4, i_mem_ready=0, back-to-back SW -> 3 accepted, then o_store_ready=0; one dequeue -> o_store_ready=1 next cycle.
REQ-036 Resident SW at 0x2004, check 0x2006 -> o_load_hazard=1; check 0x2008 -> o_load_hazard=0.
REQ-037 Assert i_rst mid-cycle with 2 entries -> o_mem_valid=0 immediately, count=0; the first store after release is presented normally.
